sram_port_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 27 ++
 rtl/sram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_sram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//   Shared types for the IF/MEM memory-port arbiter.
//   - state_e : arbiter FSM states (one outstanding transaction at a time)
//   - owner_e : which requester owns the current transaction
//   - SZ_*    : access-size encodings carried on *_size / mem_size
// ----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Encoding matches the rr_arb2 request index (0 = inst, 1 = data).
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin pick. The history bit lives in the
//   parent so this block stays purely combinational.
//   Ports:
//     req0, req1 : request lines (index 0 = instruction, 1 = data)
//     last       : index of the requester granted most recently
//     grant      : one-hot grant, bit n for req n; zero when no request
// ----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] grant
);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = {req1, req0};
    if (req0 && req1) begin
      // Contention: favour whoever was not served last.
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one SRAM-like memory port between the instruction-fetch (i_*) and
//   load/store (d_*) requesters. One transaction in flight at a time:
//   IDLE (grant) -> ADDR (mem_req until mem_addr_ok) -> DATA (wait for
//   mem_data_ok, forward to owner) -> IDLE.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     {i,d}_req/wr/size/addr/wstrb/wdata : requester command inputs
//     {i,d}_addr_ok         : 1-cycle pulse when that requester is granted
//     {i,d}_data_ok/rdata   : 1-cycle completion pulse, read data alongside
//     mem_req + mem_* fields: downstream request, fields from latched regs
//     mem_addr_ok/data_ok/rdata : downstream handshake and read data
//     busy                  : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic                i_wr,
  input  logic [1:0]          i_size,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_rdata,

  input  logic                d_req,
  input  logic                d_wr,
  input  logic [1:0]          d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, last_q;
  logic                wr_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [1:0]          grant;
  logic                take;
  logic                take_d;
  logic                data_fire;

  rr_arb2 u_rr_arb2 (
    .req0  (i_req),
    .req1  (d_req),
    .last  (last_q == OWN_DATA),
    .grant (grant)
  );

  // Grants only happen in IDLE; rst gates the combinational pulse so that a
  // request held during reset never produces an addr_ok.
  assign take      = (state_q == ST_IDLE) && !rst && (grant != 2'b00);
  assign take_d    = grant[1];
  assign data_fire = (state_q == ST_DATA) && mem_data_ok;

  assign i_addr_ok = take && grant[0];
  assign d_addr_ok = take && grant[1];
  assign i_data_ok = data_fire && (owner_q == OWN_INST);
  assign d_data_ok = data_fire && (owner_q == OWN_DATA);
  assign i_rdata   = i_data_ok ? mem_rdata : '0;
  assign d_rdata   = d_data_ok ? mem_rdata : '0;

  assign mem_req   = (state_q == ST_ADDR);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take)        state_d = ST_ADDR;
      // A simultaneous mem_data_ok here is ignored: only the address phase
      // completes.
      ST_ADDR: if (mem_addr_ok) state_d = ST_DATA;
      ST_DATA: if (mem_data_ok) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INST;
      last_q  <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q <= take_d ? OWN_DATA : OWN_INST;
        last_q  <= take_d ? OWN_DATA : OWN_INST;
        wr_q    <= take_d ? d_wr    : i_wr;
        size_q  <= take_d ? d_size  : i_size;
        addr_q  <= take_d ? d_addr  : i_addr;
        wstrb_q <= take_d ? d_wstrb : i_wstrb;
        wdata_q <= take_d ? d_wdata : i_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter. Inputs change 1 ns after the rising
//   edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [1:0]  i_size, d_size;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_wr        (i_wr),
    .i_size      (i_size),
    .i_addr      (i_addr),
    .i_wstrb     (i_wstrb),
    .i_wdata     (i_wdata),
    .i_addr_ok   (i_addr_ok),
    .i_data_ok   (i_data_ok),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_wr        (d_wr),
    .d_size      (d_size),
    .d_addr      (d_addr),
    .d_wstrb     (d_wstrb),
    .d_wdata     (d_wdata),
    .d_addr_ok   (d_addr_ok),
    .d_data_ok   (d_data_ok),
    .d_rdata     (d_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with a zero-wait memory. Entered in cycle 0 with the
  // requester's inputs already driven; returns 1 ns into the cycle after
  // data_ok (the next possible grant cycle).
  task automatic txn(input bit exp_d, input logic [31:0] exp_addr,
                     input logic [31:0] rd);
    @(negedge clk);
    check("addr_ok_owner", exp_d ? d_addr_ok : i_addr_ok, 1'b1);
    check("addr_ok_other", exp_d ? i_addr_ok : d_addr_ok, 1'b0);
    step();
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("c1_mem_req",  mem_req,  1'b1);
    check("c1_mem_addr", mem_addr, exp_addr);
    check("c1_busy",     busy,     1'b1);
    check("c1_no_dok",   {i_data_ok, d_data_ok}, 2'b00);
    step();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    @(negedge clk);
    check("c2_mem_req",     mem_req, 1'b0);
    check("data_ok_owner",  exp_d ? d_data_ok : i_data_ok, 1'b1);
    check("data_ok_other",  exp_d ? i_data_ok : d_data_ok, 1'b0);
    check("rdata_owner",    exp_d ? d_rdata : i_rdata, rd);
    check("rdata_other",    exp_d ? i_rdata : d_rdata, 32'h0);
    step();
    mem_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    {i_req, i_wr, d_req, d_wr} = '0;
    {i_size, d_size} = '0;
    {i_addr, d_addr, i_wdata, d_wdata} = '0;
    {i_wstrb, d_wstrb} = '0;
    {mem_addr_ok, mem_data_ok} = '0;
    mem_rdata = '0;

    // Reset state; a request held during reset must not be acknowledged.
    d_req = 1'b1;
    @(negedge clk);
    check("rst_addr_ok", {i_addr_ok, d_addr_ok}, 2'b00);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy",    busy,    1'b0);
    check("rst_fields",  {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata}, 64'h0);
    d_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single data read.
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h1000_0004;
    txn(1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    d_req = 1'b0;
    @(negedge clk);
    check("rd_busy_fall", busy, 1'b0);
    check("rd_no_regrant", {i_addr_ok, d_addr_ok}, 2'b00);

    // Contention from a fresh reset: D, I, D, I.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0000; i_size = 2'd2;
    d_req = 1'b1; d_addr = 32'h1000_0008;
    txn(1'b1, 32'h1000_0008, 32'h1111_1111);
    txn(1'b0, 32'hBFC0_0000, 32'h2222_2222);
    txn(1'b1, 32'h1000_0008, 32'h3333_3333);
    txn(1'b0, 32'hBFC0_0000, 32'h4444_4444);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("cont_idle", busy, 1'b0);

    // Back-to-back fetches: second addr_ok the cycle after first data_ok.
    step();
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    txn(1'b0, 32'hBFC0_0000, 32'h3C1D_0000);
    i_addr = 32'hBFC0_0004;
    txn(1'b0, 32'hBFC0_0004, 32'h27BD_0010);
    i_req = 1'b0;
    @(negedge clk);
    check("b2b_idle", busy, 1'b0);

    // Byte write with three address-phase wait states.
    step();
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_addr = 32'h1000_0006;
    d_wstrb = 4'b0100; d_wdata = 32'h00AB_0000;
    @(negedge clk);
    check("wr_addr_ok", d_addr_ok, 1'b1);
    step();
    d_req = 1'b0; d_wr = 1'b0; d_wstrb = 4'hF; d_wdata = 32'hFFFF_FFFF;
    d_addr = 32'h0; d_size = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ws_mem_req", mem_req, 1'b1);
      check("ws_fields", {mem_wr, mem_size, mem_wstrb, mem_addr},
            {1'b1, 2'd0, 4'b0100, 32'h1000_0006});
      check("ws_wdata", mem_wdata, 32'h00AB_0000);
      check("ws_busy", busy, 1'b1);
      step();
    end
    mem_addr_ok = 1'b1;
    @(negedge clk);
    check("ws_acc_req", mem_req, 1'b1);
    step();
    mem_addr_ok = 1'b0;
    @(negedge clk);
    check("wd_mem_req", mem_req, 1'b0);
    check("wd_busy", busy, 1'b1);
    check("wd_no_dok", d_data_ok, 1'b0);
    step();
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("wr_data_ok", d_data_ok, 1'b1);
    check("wr_i_quiet", {i_addr_ok, i_data_ok}, 2'b00);
    step();
    mem_data_ok = 1'b0;
    @(negedge clk);
    check("wr_busy_fall", busy, 1'b0);

    // Spurious mem_data_ok in IDLE and in ADDR.
    step();
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("sp_idle_dok", {i_data_ok, d_data_ok}, 2'b00);
    check("sp_idle_busy", busy, 1'b0);
    step();
    mem_data_ok = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0008;
    @(negedge clk);
    check("sp_grant", i_addr_ok, 1'b1);
    step();
    i_req = 1'b0;
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("sp_addr_dok", {i_data_ok, d_data_ok}, 2'b00);
    check("sp_addr_hold", mem_req, 1'b1);
    step();
    mem_addr_ok = 1'b1;  // mem_data_ok still high: only addr_ok counts
    @(negedge clk);
    check("sp_both_dok", {i_data_ok, d_data_ok}, 2'b00);
    step();
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    @(negedge clk);
    check("sp_in_data", {mem_req, busy, i_data_ok}, 3'b010);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    check("sp_dok", i_data_ok, 1'b1);
    check("sp_rdata", i_rdata, 32'h0000_0013);
    step();
    mem_data_ok = 1'b0;

    // Reset mid-ADDR, then a late mem_data_ok.
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h1000_000C;
    @(negedge clk);
    check("mr_grant", d_addr_ok, 1'b1);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("mr_in_addr", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_mem_req", mem_req, 1'b0);
    check("mr_busy", busy, 1'b0);
    check("mr_addr", mem_addr, 32'h0);
    step();
    rst = 1'b0;
    mem_data_ok = 1'b1;
    @(negedge clk);
    check("mr_late_dok", {i_data_ok, d_data_ok}, 2'b00);
    check("mr_late_busy", busy, 1'b0);
    step();
    mem_data_ok = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
